// File: rtl/pipe_pkg.sv
// Shared constants for the integer pipeline hazard controller:
// stage indices, multiply-timer state encoding and the NOP word.
package pipe_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic {
    MT_IDLE = 1'b0,
    MT_BUSY = 1'b1
  } mult_state_e;

  // Word loaded into a bubbled stage register (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_mult_timer.sv
// Multiply occupancy timer: keeps a multiply in EX for MULT_CYCLES cycles
// and requests a stall of the front of the pipe while it runs.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   MT_IDLE | no multiply in progress; a valid multiply in EX starts one
//   MT_BUSY | multiply running; cnt_q counts remaining stall cycles
module pipe_mult_timer
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic mstall,
  output logic mult_busy
);

  localparam int TW = (MULT_CYCLES > 2) ? $clog2(MULT_CYCLES - 1) : 1;
  localparam int LOAD_INT = (MULT_CYCLES > 1) ? (MULT_CYCLES - 2) : 0;
  localparam logic [TW-1:0] LOAD_VAL = TW'(LOAD_INT);
  localparam bit MULT_EN = (MULT_CYCLES > 1);

  mult_state_e state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mstall  = 1'b0;
    case (state_q)
      MT_IDLE: begin
        if (start && MULT_EN) begin
          mstall  = 1'b1;
          state_d = MT_BUSY;
          cnt_d   = LOAD_VAL;
        end
      end
      MT_BUSY: begin
        // Counter at zero is the final EX cycle: the multiply moves on.
        if (cnt_q == '0) begin
          state_d = MT_IDLE;
        end else begin
          mstall = 1'b1;
          cnt_d  = cnt_q - TW'(1);
        end
      end
      default: state_d = MT_IDLE;
    endcase
  end

  assign mult_busy = (state_q == MT_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/occupancy controller: load-use and multiply interlocks,
// taken-branch squash of the fetch slot, stage valid bits, perf counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int EX_STAGE    = STG_EX,
  parameter int REG_W       = 5,
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic                  id_uses_a,
  input  logic                  id_uses_b,
  input  logic [REG_W-1:0]      id_rs_a,
  input  logic [REG_W-1:0]      id_rs_b,
  input  logic                  ex_is_load,
  input  logic                  ex_is_mult,
  input  logic                  ex_reg_write,
  input  logic [REG_W-1:0]      ex_write_reg,
  input  logic                  branch_taken,
  output logic [NUM_STAGES-1:0] stage_hold,
  output logic [NUM_STAGES-1:0] stage_bubble,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  mult_busy,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int ID_STAGE = EX_STAGE - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic mstall;
  logic lu;
  logic src_match;
  logic flush;

  pipe_mult_timer #(
    .MULT_CYCLES(MULT_CYCLES)
  ) u_mult_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (stage_valid[EX_STAGE] & ex_is_mult),
    .mstall   (mstall),
    .mult_busy(mult_busy)
  );

  assign src_match = (id_uses_a && (id_rs_a == ex_write_reg)) ||
                     (id_uses_b && (id_rs_b == ex_write_reg));

  assign lu = stage_valid[ID_STAGE] && stage_valid[EX_STAGE] &&
              ex_is_load && ex_reg_write &&
              (ex_write_reg != '0) && src_match;

  // A branch seen during a stall is dropped; the held ID branch re-asserts it.
  assign flush = branch_taken && !mstall && !lu;

  always_comb begin
    stage_hold   = '0;
    stage_bubble = '0;
    if (mstall) begin
      for (int i = 0; i <= EX_STAGE; i++) stage_hold[i] = 1'b1;
      stage_bubble[EX_STAGE+1] = 1'b1;
    end else if (lu) begin
      for (int i = 0; i <= ID_STAGE; i++) stage_hold[i] = 1'b1;
      stage_bubble[EX_STAGE] = 1'b1;
    end else if (flush) begin
      stage_bubble[ID_STAGE] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
    end else begin
      stage_valid[0] <= stage_hold[0] ? stage_valid[0] : fetch_valid;
      for (int i = 1; i < NUM_STAGES; i++) begin
        if (stage_hold[i])        stage_valid[i] <= stage_valid[i];
        else if (stage_bubble[i]) stage_valid[i] <= 1'b0;
        else                      stage_valid[i] <= stage_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((mstall || lu) && (stall_cycles != CNT_MAX))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations
// plus a per-cycle comparison against an occupancy-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int NS = 5;
  localparam int EX = 2;
  localparam int ID = 1;
  localparam int RW = 5;
  localparam int MC = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_valid = 1'b0;
  logic          id_uses_a = 1'b0, id_uses_b = 1'b0;
  logic [RW-1:0] id_rs_a = '0, id_rs_b = '0;
  logic          ex_is_load = 1'b0, ex_is_mult = 1'b0, ex_reg_write = 1'b0;
  logic [RW-1:0] ex_write_reg = '0;
  logic          branch_taken = 1'b0;
  logic [NS-1:0] stage_hold, stage_bubble, stage_valid;
  logic          mult_busy;
  logic [CW-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .NUM_STAGES(NS), .EX_STAGE(EX), .REG_W(RW), .MULT_CYCLES(MC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .ex_is_load(ex_is_load), .ex_is_mult(ex_is_mult),
    .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .branch_taken(branch_taken),
    .stage_hold(stage_hold), .stage_bubble(stage_bubble),
    .stage_valid(stage_valid), .mult_busy(mult_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: stage occupancy plus the occupancy index of a running multiply.
  logic [NS-1:0] m_valid;
  int            m_occ;
  int            m_stalls, m_flush;
  bit            m_init = 1'b0;

  always @(negedge clk) begin : model_chk
    logic lu_e, entry, ms_e, fl_e;
    int cur;
    logic [NS-1:0] h_e, b_e, nv;
    lu_e = 1'b0; entry = 1'b0; ms_e = 1'b0; fl_e = 1'b0; cur = 0;
    h_e = '0; b_e = '0; nv = '0;
    if (m_init) begin
      lu_e = m_valid[ID] && m_valid[EX] && ex_is_load && ex_reg_write &&
             (ex_write_reg != 0) &&
             ((id_uses_a && id_rs_a == ex_write_reg) || (id_uses_b && id_rs_b == ex_write_reg));
      entry = (m_occ == 0) && m_valid[EX] && ex_is_mult && (MC > 1);
      cur   = entry ? 1 : m_occ;
      ms_e  = (cur >= 1) && (cur < MC);
      fl_e  = !ms_e && !lu_e && branch_taken;
      for (int i = 0; i < NS; i++) begin
        h_e[i] = ms_e ? (i <= EX) : lu_e ? (i <= ID) : 1'b0;
        b_e[i] = ms_e ? (i == EX + 1) : lu_e ? (i == EX) : (fl_e && i == ID);
      end
      check("model_hold",   32'(stage_hold),   32'(h_e));
      check("model_bubble", 32'(stage_bubble), 32'(b_e));
      check("model_valid",  32'(stage_valid),  32'(m_valid));
      check("model_busy",   32'(mult_busy),    32'(m_occ != 0));
      check("model_stalls", 32'(stall_cycles), 32'(m_stalls));
      check("model_flush",  32'(flush_count),  32'(m_flush));
    end
    if (rst) begin
      m_valid = '0; m_occ = 0; m_stalls = 0; m_flush = 0; m_init = 1'b1;
    end else if (m_init) begin
      nv[0] = h_e[0] ? m_valid[0] : fetch_valid;
      for (int i = 1; i < NS; i++)
        nv[i] = h_e[i] ? m_valid[i] : (b_e[i] ? 1'b0 : m_valid[i-1]);
      m_valid = nv;
      m_occ   = ((cur >= 1) && (cur < MC)) ? cur + 1 : 0;
      if ((ms_e || lu_e) && m_stalls < CMAX) m_stalls++;
      if (fl_e && m_flush < CMAX) m_flush++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    id_uses_a = 0; id_uses_b = 0; id_rs_a = '0; id_rs_b = '0;
    ex_is_load = 0; ex_is_mult = 0; ex_reg_write = 0; ex_write_reg = '0;
    branch_taken = 0;
  endtask

  task automatic do_reset_fill;
    rst = 1; clr_in(); fetch_valid = 0;
    tick(); tick();
    rst = 0; fetch_valid = 1;
    repeat (5) tick();
  endtask

  task automatic set_lu_r3;
    ex_is_load = 1; ex_reg_write = 1; ex_write_reg = 5'd3;
    id_uses_a = 1; id_rs_a = 5'd5; id_uses_b = 1; id_rs_b = 5'd3;
  endtask

  initial begin
    tick();

    // Load-use on regB: single stall cycle, then released.
    do_reset_fill();
    check("fill_valid", 32'(stage_valid), 32'(5'b11111));
    set_lu_r3();
    #3;
    check("lu_hold",   32'(stage_hold),   32'(5'b00011));
    check("lu_bubble", 32'(stage_bubble), 32'(5'b00100));
    tick(); #3;
    check("lu_stall_cnt",     32'(stall_cycles), 32'd1);
    check("lu_release_hold",  32'(stage_hold),   32'd0);
    check("lu_release_valid", 32'(stage_valid),  32'(5'b11011));
    tick();

    // Load to r0 with ID reading r0: never a hazard.
    clr_in();
    repeat (3) tick();
    ex_is_load = 1; ex_reg_write = 1; ex_write_reg = '0;
    id_uses_a = 1; id_rs_a = '0; id_uses_b = 1; id_rs_b = '0;
    #3;
    check("r0_hold",   32'(stage_hold),   32'd0);
    check("r0_bubble", 32'(stage_bubble), 32'd0);
    tick(); clr_in();

    // Multiply: three stall cycles, busy on the last two of them.
    do_reset_fill();
    ex_is_mult = 1;
    #3;
    check("mul_hold_c1",   32'(stage_hold),   32'(5'b00111));
    check("mul_bubble_c1", 32'(stage_bubble), 32'(5'b01000));
    check("mul_busy_c1",   32'(mult_busy),    32'd0);
    for (int c = 2; c <= 3; c++) begin
      tick(); #3;
      check("mul_hold_cn",   32'(stage_hold),   32'(5'b00111));
      check("mul_bubble_cn", 32'(stage_bubble), 32'(5'b01000));
      check("mul_busy_cn",   32'(mult_busy),    32'd1);
    end
    tick(); #3;
    check("mul_hold_c4",  32'(stage_hold),   32'd0);
    check("mul_busy_c4",  32'(mult_busy),    32'd1);
    check("mul_stall_cnt", 32'(stall_cycles), 32'd3);
    tick(); ex_is_mult = 0; #3;
    check("mul_busy_done", 32'(mult_busy), 32'd0);
    tick();

    // Branch without stall, then branch coinciding with a load-use stall.
    do_reset_fill();
    branch_taken = 1;
    #3;
    check("br_bubble", 32'(stage_bubble), 32'(5'b00010));
    check("br_hold",   32'(stage_hold),   32'd0);
    tick(); branch_taken = 0; #3;
    check("br_id_valid", 32'(stage_valid[ID]), 32'd0);
    check("br_flush_cnt", 32'(flush_count), 32'd1);
    repeat (3) tick();
    set_lu_r3(); branch_taken = 1;
    #3;
    check("brlu_hold",   32'(stage_hold),   32'(5'b00011));
    check("brlu_bubble", 32'(stage_bubble), 32'(5'b00100));
    tick(); #3;
    check("brrel_bubble", 32'(stage_bubble), 32'(5'b00010));
    check("brrel_hold",   32'(stage_hold),   32'd0);
    tick(); clr_in(); #3;
    check("brrel_flush_cnt", 32'(flush_count),  32'd2);
    check("brrel_stall_cnt", 32'(stall_cycles), 32'd1);
    tick();

    // Reset while the multiply timer is BUSY with one stall left.
    do_reset_fill();
    ex_is_mult = 1;
    tick(); tick();
    rst = 1;
    #3;
    check("rstbusy_pre_busy", 32'(mult_busy), 32'd1);
    tick(); rst = 0; #3;
    check("rstbusy_busy",  32'(mult_busy),    32'd0);
    check("rstbusy_valid", 32'(stage_valid),  32'd0);
    check("rstbusy_stall", 32'(stall_cycles), 32'd0);
    check("rstbusy_flush", 32'(flush_count),  32'd0);
    check("rstbusy_hold",  32'(stage_hold),   32'd0);
    tick(); clr_in();

    // Saturation: about 20 load-use stalls into a 4-bit counter.
    do_reset_fill();
    set_lu_r3();
    repeat (40) tick();
    #3;
    check("sat_stall_cnt", 32'(stall_cycles), 32'(CMAX));
    tick(); clr_in();

    // Mixed traffic with small register numbers so hazards collide often.
    do_reset_fill();
    repeat (300) begin
      rst          = ($urandom_range(0, 59) == 0);
      fetch_valid  = 1'($urandom_range(0, 3) != 0);
      id_uses_a    = 1'($urandom_range(0, 1));
      id_uses_b    = 1'($urandom_range(0, 1));
      id_rs_a      = 5'($urandom_range(0, 3));
      id_rs_b      = 5'($urandom_range(0, 3));
      ex_is_load   = 1'($urandom_range(0, 1));
      ex_is_mult   = ($urandom_range(0, 5) == 0);
      ex_reg_write = 1'($urandom_range(0, 3) != 0);
      ex_write_reg = 5'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 4) == 0);
      tick();
    end
    rst = 0; clr_in();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised stall/flush/occupancy controller for the N-stage integer pipeline.
- Drives the per-stage reg_lock (hold) and bubble controls that are currently tied inactive.
- Adds three behaviours: load-use interlock, a multi-cycle multiply busy interlock, and taken-branch squash of the fetch slot.
- Tracks per-stage valid bits and keeps saturating stall/flush performance counters.

Parameters:
- NUM_STAGES, 5: pipeline depth; stage 0 = IF, bit i of every vector = stage i; legal range 4..8.
- EX_STAGE, 2: index of the execute stage; ID = EX_STAGE-1; must satisfy 2 <= EX_STAGE <= NUM_STAGES-2.
- REG_W, 5: register specifier width.
- MULT_CYCLES, 4: execute-stage occupancy of a multiply; a value of 1 means no multiply stall.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  IF produced an instruction this cycle.
- id_uses_a, id_uses_b  in  1 each  ID instruction reads regA / regB.
- id_rs_a, id_rs_b  in  REG_W each  ID source registers.
- ex_is_load  in  1  EX instruction is a load.
- ex_is_mult  in  1  EX instruction is a multiply.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_write_reg  in  REG_W  EX destination register.
- branch_taken  in  1  jump or taken branch resolved in ID.
- stage_hold  out  NUM_STAGES  combinational; 1 = stage register keeps its value.
- stage_bubble  out  NUM_STAGES  combinational; 1 = stage register loads a NOP with valid=0.
- stage_valid  out  NUM_STAGES  registered occupancy.
- mult_busy  out  1  registered; multiply FSM is in BUSY.
- stall_cycles  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flushes.

Behaviour:
- Reset: stage_valid=0, FSM=IDLE, internal down-counter=0, both perf counters=0, mult_busy=0.
- Reset has priority over every other event, including a reset during BUSY or during a flush.
- Load-use hazard (lu), all terms required:
  - stage_valid[ID] and stage_valid[EX];
  - ex_is_load and ex_reg_write;
  - ex_write_reg != 0;
  - (id_uses_a and id_rs_a == ex_write_reg) or (id_uses_b and id_rs_b == ex_write_reg).
- Multiply FSM, states IDLE and BUSY:
  - IDLE->BUSY when stage_valid[EX] and ex_is_mult and MULT_CYCLES>1; counter loads MULT_CYCLES-2.
  - In BUSY the counter decrements each cycle. BUSY->IDLE on the cycle the counter is 0.
  - Total EX occupancy is MULT_CYCLES cycles.
- mstall = (IDLE and the entry condition holds) or (BUSY and counter != 0).
- Priority is mstall > lu > branch_taken. Only one action applies per cycle.
- mstall action: stage_hold[0..EX_STAGE]=1; stage_bubble[EX_STAGE+1]=1; later stages advance.
- lu action: stage_hold[0..ID]=1; stage_bubble[EX_STAGE]=1. Latency is exactly one stall cycle, after which forwarding covers the dependency.
- branch_taken action (only when neither stall is active): stage_bubble[ID]=1, squashing the wrong-path fetch; no hold.
  - A branch_taken that coincides with a stall is ignored. The held ID branch re-asserts it on the release cycle.
- Valid update for each stage i>0:
  - hold: keep;
  - bubble: 0;
  - otherwise: stage_valid[i-1].
- Valid update for stage 0: keep when held, otherwise fetch_valid.
- Invariant: stage_hold and stage_bubble are never both 1 for the same stage.
- stall_cycles increments on every mstall or lu cycle. flush_count increments on every applied branch flush. Both saturate at all ones and never wrap.
- Hazard logic ignores register 0. Invalid stages never create hazards.

Decomposition:
- Shared package pipe_pkg holds:
  - stage index constants (IF, ID, EX, MEM, WB);
  - FSM state encoding (IDLE=0, BUSY=1);
  - a NOP instruction constant.
- One sub-module: pipe_mult_timer, containing the IDLE/BUSY FSM and down-counter. It outputs mstall and mult_busy.

Test Plan:
- Reset during BUSY at count 1 -> next cycle: mult_busy=0, stage_valid=0, counters=0, stage_hold=0.
- Load r3 in EX, ID reads id_rs_b=3 -> one cycle with stage_hold=00011, stage_bubble=00100; stall_cycles=1; no stall on the following cycle.
- Load to r0 with ID reading r0 -> no stall; stage_hold=0.
- Multiply in EX with MULT_CYCLES=4 -> stage_hold[0..2]=1 and stage_bubble[3]=1 for 3 cycles; mult_busy high for 2 of them; stall_cycles=3.
- branch_taken with no stall -> stage_bubble=00010, stage_valid[1]=0 next cycle, flush_count=1. branch_taken during lu -> ignored; flush applies on the release cycle.
- Force stall_cycles to all ones (CNT_W=4, 15 stalls), then one more stall -> remains 15.
